// File: rtl/systolic_dataflow_ctrl_if.sv
// systolic_dataflow_ctrl_if: job request and grid control/index bundle of the systolic sequencer
interface systolic_dataflow_ctrl_if #(
  parameter int ROWS = 4,
  parameter int CNT_W = 16
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic start;
  logic mode;
  logic [CNT_W-1:0] num_vectors;
  logic busy;
  logic done;
  logic output_stationary;
  logic array_clear;
  logic preload_valid;
  logic [RW-1:0] preload_row;
  logic in_valid;
  logic [CNT_W-1:0] in_idx;
  logic out_valid;
  logic [CNT_W-1:0] out_idx;
  modport master (
    output start, mode, num_vectors,
    input busy, done, output_stationary, array_clear, preload_valid, preload_row,
    input in_valid, in_idx, out_valid, out_idx
  );
  modport slave (
    input start, mode, num_vectors,
    output busy, done, output_stationary, array_clear, preload_valid, preload_row,
    output in_valid, in_idx, out_valid, out_idx
  );
endinterface

// File: rtl/systolic_dataflow_ctrl.sv
// systolic_dataflow_ctrl: WS/OS job sequencer driving registered control and index strobes of a PE grid
module systolic_dataflow_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  systolic_dataflow_ctrl_if.slave bus
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] LAT = (CNT_W+1)'(ROWS + COLS - 1);
  localparam logic [CNT_W:0] LAST_ROW = (CNT_W+1)'(ROWS - 1);
  typedef enum logic [2:0] {IDLE, PRELOAD, CLEAR, STREAM, FLUSH, READOUT, DONE} state_t;
  state_t st, st_n;
  logic [CNT_W:0] p, p_n, m, s_end, f_end;
  logic os, os_n;
  logic busy_n, done_n, clr_n, pv_n, iv_n, ov_n;
  logic [RW-1:0] row_n;
  logic [CNT_W-1:0] in_n, out_n;
  // p runs unbroken through STREAM and FLUSH so WS results trail inputs by exactly LAT
  assign s_end = m - ONE;
  assign f_end = m + LAT - ONE;
  assign bus.output_stationary = os;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      p <= '0;
      m <= '0;
      os <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.array_clear <= 1'b0;
      bus.preload_valid <= 1'b0;
      bus.preload_row <= '0;
      bus.in_valid <= 1'b0;
      bus.in_idx <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx <= '0;
    end else begin
      st <= st_n;
      p <= p_n;
      os <= os_n;
      if (st == IDLE && bus.start) m <= {1'b0, bus.num_vectors};
      bus.busy <= busy_n;
      bus.done <= done_n;
      bus.array_clear <= clr_n;
      bus.preload_valid <= pv_n;
      bus.preload_row <= row_n;
      bus.in_valid <= iv_n;
      bus.in_idx <= in_n;
      bus.out_valid <= ov_n;
      bus.out_idx <= out_n;
    end
  end
  always_comb begin
    st_n = st;
    p_n = p + ONE;
    os_n = os;
    unique case (st)
      IDLE: begin
        p_n = '0;
        if (bus.start) begin
          os_n = bus.mode;
          st_n = bus.num_vectors == '0 ? DONE : bus.mode ? CLEAR : PRELOAD;
        end
      end
      PRELOAD: if (p == LAST_ROW) begin st_n = STREAM; p_n = '0; end
      CLEAR: begin st_n = STREAM; p_n = '0; end
      STREAM: if (p == s_end) st_n = FLUSH;
      FLUSH: if (p == f_end) begin st_n = os ? READOUT : DONE; p_n = '0; end
      READOUT: if (p == LAST_ROW) begin st_n = DONE; p_n = '0; end
      DONE: begin st_n = IDLE; p_n = '0; end
      default: begin st_n = IDLE; p_n = '0; end
    endcase
  end
  always_comb begin
    busy_n = st_n != IDLE;
    done_n = st_n == DONE;
    clr_n = st_n == CLEAR;
    pv_n = st_n == PRELOAD || st_n == READOUT;
    iv_n = st_n == STREAM;
    ov_n = st_n == READOUT || (!os_n && (st_n == STREAM || st_n == FLUSH) && p_n >= LAT);
    row_n = pv_n ? p_n[RW-1:0] : bus.preload_row;
    in_n = iv_n ? p_n[CNT_W-1:0] : bus.in_idx;
    out_n = st_n == READOUT ? p_n[CNT_W-1:0] : ov_n ? p_n[CNT_W-1:0] - LAT[CNT_W-1:0] : bus.out_idx;
  end
endmodule

// File: tb/tb_systolic_dataflow_ctrl.sv
// tb_systolic_dataflow_ctrl: randomized jobs against a timeline model, checked by a strobe scoreboard
module tb_systolic_dataflow_ctrl;
  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 16;
  localparam int LAT = R + C - 1;
  typedef struct {int kind; int cyc; int idx;} ev_t;
  logic clk, reset;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;
  int acc = -10;
  int job_end = -1;
  int os_prev = 0, os_next = 0, os_at = 0;
  ev_t sb[$];
  string nm[5] = '{"preload", "in", "out", "clear", "done"};
  systolic_dataflow_ctrl_if #(.ROWS(R), .CNT_W(W)) bus ();
  systolic_dataflow_ctrl_if #(.ROWS(1), .CNT_W(W)) bus1 ();
  systolic_dataflow_ctrl #(.ROWS(R), .COLS(C), .CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  systolic_dataflow_ctrl #(.ROWS(1), .COLS(1), .CNT_W(W)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, a, e);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_strobes"}, int'({bus.busy, bus.done, bus.output_stationary, bus.array_clear,
                               bus.preload_valid, bus.in_valid, bus.out_valid}), 0);
    chk({n, "_idx"}, int'(bus.preload_row) + int'(bus.in_idx) + int'(bus.out_idx), 0);
  endtask
  // Expected timeline of every strobe, derived from the job rules rather than any state machine
  task automatic model(input int c, input bit md, input int n);
    acc = c;
    os_prev = os_at <= c ? os_next : os_prev;
    os_next = md;
    os_at = c + 1;
    if (n == 0) job_end = c + 1;
    else if (!md) begin
      for (int r = 0; r < R; r++) sb.push_back('{0, c + 1 + r, r});
      for (int i = 0; i < n; i++) begin
        sb.push_back('{1, c + 1 + R + i, i});
        sb.push_back('{2, c + 1 + R + i + LAT, i});
      end
      job_end = c + R + n + LAT + 1;
    end else begin
      sb.push_back('{3, c + 1, 0});
      for (int i = 0; i < n; i++) sb.push_back('{1, c + 2 + i, i});
      for (int r = 0; r < R; r++) begin
        sb.push_back('{0, c + 2 + n + LAT + r, r});
        sb.push_back('{2, c + 2 + n + LAT + r, r});
      end
      job_end = c + 2 + n + LAT + R;
    end
    sb.push_back('{4, job_end, 0});
  endtask
  task automatic job(input bit md, input int n, input int spur_at, input bit spur_md, input int rst_at);
    int c;
    while (cyc <= job_end) begin @(posedge clk); #1; end
    c = cyc;
    bus.start = 1;
    bus.mode = md;
    bus.num_vectors = W'(n);
    model(c, md, n);
    @(posedge clk); #1;
    bus.num_vectors = W'($urandom);
    while (cyc <= job_end) begin
      bus.start = (cyc - c == spur_at);
      bus.mode = spur_md;
      reset = (cyc - c == rst_at);
      @(posedge clk); #1;
      if (reset) begin
        reset = 0;
        sb.delete();
        job_end = cyc - 1;
        os_prev = 0;
        os_next = 0;
        chk_zero("mid_reset");
      end
    end
    bus.start = 0;
  endtask
  always @(negedge clk) begin
    logic [4:0] s;
    int v[5];
    int f;
    if (mon_en) begin
      s = {bus.done, bus.array_clear, bus.out_valid, bus.in_valid, bus.preload_valid};
      v = '{int'(bus.preload_row), int'(bus.in_idx), int'(bus.out_idx), 0, 0};
      for (int k = 0; k < 5; k++) if (s[k]) begin
        f = -1;
        foreach (sb[i]) if (f < 0 && sb[i].kind == k) f = i;
        if (f < 0) begin
          checks++;
          failures++;
          $display("FAIL %s unexpected at cycle %0d: got strobe expected none", nm[k], cyc);
        end else begin
          chk({nm[k], "_cycle"}, cyc, sb[f].cyc);
          chk({nm[k], "_idx"}, v[k], sb[f].idx);
          sb.delete(f);
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed: got nothing expected idx %0d at cycle %0d", nm[sb[i].kind], sb[i].idx, sb[i].cyc);
        sb.delete(i);
      end
      chk("busy", int'(bus.busy), int'(cyc > acc && cyc <= job_end));
      chk("output_stationary", int'(bus.output_stationary), cyc >= os_at ? os_next : os_prev);
    end
  end
  initial begin
    int n, sp, rs;
    reset = 1;
    bus.start = 0;
    bus.mode = 0;
    bus.num_vectors = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk_zero("reset");
    acc = cyc - 1;
    job_end = cyc - 1;
    mon_en = 1;
    job(0, 5, -1, 0, -1);
    job(1, 3, -1, 0, -1);
    job(0, 10, -1, 0, -1);
    job(0, 5, -1, 0, 8);
    job(0, 5, -1, 0, -1);
    job(0, 5, 3, 1, -1);
    job(0, 0, -1, 0, -1);
    job(1, 1, 2, 0, -1);
    for (int j = 0; j < 40; j++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : ($urandom_range(0, 5) == 0 ? $urandom_range(20, 40) : $urandom_range(1, 12));
      sp = $urandom_range(0, 1) ? int'($urandom_range(1, 20)) : -1;
      rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : -1;
      job(1'($urandom), n, sp, 1'($urandom), rs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    while (cyc <= job_end + 2) begin @(posedge clk); #1; end
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  // 1x1 grid, OS with K=2: clear, two inputs, one flush, one readout row, done
  initial begin
    int c1, o;
    bus1.start = 0;
    bus1.mode = 0;
    bus1.num_vectors = '0;
    wait (mon_en);
    @(posedge clk); #1;
    c1 = cyc;
    bus1.start = 1;
    bus1.mode = 1;
    bus1.num_vectors = W'(2);
    repeat (7) begin
      @(posedge clk); #1;
      bus1.start = 0;
      o = cyc - c1;
      chk("u1_strobes", int'({bus1.array_clear, bus1.in_valid, bus1.preload_valid, bus1.out_valid, bus1.done, bus1.busy}),
          int'({o == 1, o == 2 || o == 3, o == 5, o == 5, o == 6, o <= 6}));
      if (o == 2 || o == 3) chk("u1_in_idx", int'(bus1.in_idx), o - 2);
      if (o == 5) chk("u1_row", int'(bus1.preload_row) + int'(bus1.out_idx), 0);
      chk("u1_os", int'(bus1.output_stationary), 1);
    end
  end
endmodule
